usrt_tx: RTL and testbench
==========================

Name: usrt_tx

Overview:
Serial transmit engine of the USRT. It sits directly downstream of the status register: it takes the programmed baud divider and parity mode, and it drives the i_Tx_Busy status bit back into that register. It accepts parallel bytes over a valid/ready handshake. Each byte is shifted out as a start/data/parity/stop frame, together with a transmit clock o_Sclk for the synchronous link partner.

Parameters:
DATA_BITS, 8, payload bits per frame.
DIV_WIDTH, 8, width of the baud divider input.

Ports:
i_Pclk  input  1  system clock; all logic on rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Tx_Valid  input  1  byte offered on i_Tx_Data.
i_Tx_Data  input  DATA_BITS  byte to send.
o_Tx_Ready  output  1  block can accept a byte this cycle.
i_Baud_Div  input  DIV_WIDTH  bit period = 2*(i_Baud_Div+1) Pclk cycles.
i_Parity  input  2  00 none, 01 even, 10 odd, 11 none.
o_Tx_Serial  output  1  serial data line; idle high.
o_Sclk  output  1  transmit clock; idle high.
o_Tx_Busy  output  1  frame in progress; wired to status register i_Tx_Busy.

Behaviour:
- Clocking and reset: one clock, i_Pclk. i_Reset is synchronous and active-high.
- Reset values: o_Tx_Serial=1, o_Sclk=1, o_Tx_Busy=0, o_Tx_Ready=1, state IDLE, counters 0.
- Reset mid-frame aborts the frame at the next edge. No partial bits are completed.
- Handshake: a byte is accepted on an edge where i_Tx_Valid && o_Tx_Ready. Data is don't-care otherwise.
- At accept, i_Tx_Data, i_Baud_Div and i_Parity are latched. Input changes during a frame are ignored.
- o_Tx_Ready = !o_Tx_Busy. This changes when the optional feature is enabled.
- o_Tx_Busy rises on the edge after accept. It falls on the edge that ends the stop bit.
- Timing: let P = 2*(DIV+1), using the latched divider.
  - Bit counter runs 0..P-1.
  - o_Sclk = 0 while the counter is <= DIV, and 1 otherwise.
  - o_Tx_Serial updates only at bit start (Sclk falling). The partner samples on the Sclk rising edge.
- First bit timing: the start bit drives o_Tx_Serial=0 from the edge after accept. One-cycle latency.
- FSM:
  - IDLE -> START on accept.
  - START -> DATA after P cycles.
  - DATA shifts DATA_BITS bits, LSB first, P cycles each.
  - DATA -> PARITY if parity is enabled, else -> STOP.
  - PARITY (one bit) -> STOP.
  - STOP (o_Tx_Serial=1, one bit) -> IDLE.
- Parity bit: even = XOR of data bits; odd = its inverse. Mode 11 is treated as none.
- Frame length: 10 bits with no parity, 11 bits with parity (DATA_BITS=8).
- Back-to-back: with i_Tx_Valid held high, the next accept happens in the cycle o_Tx_Busy is low. This gives exactly one idle Pclk cycle between frames.
- DIV=0 is legal: P=2, and Sclk alternates every cycle.
- DIV = all-ones is legal. Counter width is DIV_WIDTH+1, with no overflow.
- In IDLE, o_Sclk stays high; no free-running clock.

Optional Feature:
USRT_TX_HOLD_EN:
- Adds a one-entry holding register.
- o_Tx_Ready = !hold_full, so a byte can be accepted while a frame is in progress.
- At the end of the stop bit, if hold_full, the next frame's start bit begins on the same edge. There is no idle cycle, and o_Tx_Busy stays high.
- Config is latched when the held byte is loaded into the shifter, not when it is accepted.
- Reset clears hold_full.
- Without the macro there is no holding register, and behaviour is as above.

Decomposition:
- usrt_pkg holds:
  - parity encodings: PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10;
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the bit-index width function.
- Sub-module usrt_baud_gen:
  - inputs: divider, run enable, sync clear;
  - outputs: bit_start pulse, bit_end pulse, o_Sclk level.
- usrt_tx keeps the FSM, shifter, parity and handshake.

Test Plan:
1. Reset, DIV=0, parity 00, send 0xA5 -> o_Tx_Serial per 2-cycle bit = 0,1,0,1,0,0,1,0,1,1. o_Tx_Busy high for exactly 20 cycles, starting the edge after accept.
2. DIV=0, parity 01, send 0xA5 -> parity bit 0, 11 bits, busy for 22 cycles. With parity 10 the parity bit is 1. With parity 11 the frame is 10 bits.
3. DIV=3, send 0x01 -> bit period 8 cycles. o_Sclk is low 4 cycles then high 4 cycles, repeating. Start bit low, then data bit0 high, for 80 busy cycles.
4. i_Tx_Valid held high with 0x0F then 0xF0, DIV=0, no parity -> two frames with one idle cycle between (o_Serial=1, o_Sclk=1, o_Busy=0). With USRT_TX_HOLD_EN: zero gap, and o_Busy continuously high for 40 cycles.
5. Change i_Baud_Div from 0 to 5 and i_Parity to 01 mid-frame -> current frame keeps P=2 with no parity. The next accepted frame uses P=12 with parity.
6. Assert i_Reset in DATA state -> next edge: o_Tx_Serial=1, o_Sclk=1, o_Tx_Busy=0, o_Tx_Ready=1. A new byte is then accepted and sent normally.

Source files
------------

// File: rtl/usrt_pkg.sv
// usrt_pkg: shared types and helpers for the USRT transmit path.
// Holds parity mode encodings, the transmit FSM state type and the
// bit-index width helper.
package usrt_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Width of a counter that indexes n payload bits (at least one bit).
  function automatic int bit_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Returns {parity_enable, parity_odd}; mode 2'b11 behaves as no parity.
  function automatic logic [1:0] par_decode(input logic [1:0] mode);
    case (mode)
      PAR_EVEN: return 2'b10;
      PAR_ODD:  return 2'b11;
      PAR_NONE: return 2'b00;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/usrt_baud_gen.sv
// usrt_baud_gen: bit-period timer for the USRT transmitter.
// One bit lasts 2*(i_div+1) cycles; o_Sclk is low for the first half and
// high for the second half. When not running the counter sits at zero and
// o_Sclk is held high, so nothing toggles between frames.
module usrt_baud_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_Pclk,
  input  logic                 i_Reset,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_run,
  input  logic                 i_clear,
  output logic                 o_bit_start,
  output logic                 o_bit_end,
  output logic                 o_Sclk
);

  // One extra bit so 2*DIV+1 fits even for an all-ones divider.
  logic [DIV_WIDTH:0] cnt_q, cnt_d;
  logic [DIV_WIDTH:0] cnt_last;

  assign cnt_last = {i_div, 1'b1};

  // Counter register with synchronous reset.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Count 0..P-1 while running, wrap at the end of each bit.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || !i_run)       cnt_d = '0;
    else if (cnt_q == cnt_last)  cnt_d = '0;
    else                         cnt_d = cnt_q + 1'b1;
  end

  assign o_bit_start = i_run && (cnt_q == '0);
  assign o_bit_end   = i_run && (cnt_q == cnt_last);
  assign o_Sclk      = !i_run || (cnt_q > {1'b0, i_div});

endmodule

// File: rtl/usrt_tx.sv
// usrt_tx: USRT serial transmit engine.
// Accepts bytes over valid/ready and sends start / data (LSB first) /
// optional parity / stop, with o_Sclk for the link partner.
// Optional build macro USRT_TX_HOLD_EN adds a one-entry holding register so
// the next byte can be taken during a frame and sent with no idle gap.
module usrt_tx
  import usrt_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_Pclk,
  input  logic                 i_Reset,
  input  logic                 i_Tx_Valid,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  output logic                 o_Tx_Ready,
  input  logic [DIV_WIDTH-1:0] i_Baud_Div,
  input  logic [1:0]           i_Parity,
  output logic                 o_Tx_Serial,
  output logic                 o_Sclk,
  output logic                 o_Tx_Busy
);

  localparam int IDX_W = bit_idx_width(DATA_BITS);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   serial_q, serial_d;
  logic                   busy_q, busy_d;

  logic                   load;
  logic [DATA_BITS-1:0]   load_data;
  logic [1:0]             par_cfg;
  logic                   bit_end;
  logic                   last_data;
  // The serial register already updates on the bit_end edge, which is the
  // same edge a new bit starts, so the start pulse is not needed here.
  logic                   bit_start_unused;

  assign par_cfg   = par_decode(i_Parity);
  assign last_data = (idx_q == IDX_W'(DATA_BITS - 1));

`ifdef USRT_TX_HOLD_EN
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 accept;
  logic                 idle_next;

  assign o_Tx_Ready = !hold_full_q;
  assign accept     = i_Tx_Valid && !hold_full_q;
  assign idle_next  = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign load       = idle_next && (hold_full_q || accept);
  assign load_data  = hold_full_q ? hold_data_q : i_Tx_Data;

  // Holding register flops.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Park a byte accepted mid-frame; release it when the shifter loads it.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (load && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (accept && !load) begin
      hold_full_d = 1'b1;
      hold_data_d = i_Tx_Data;
    end
  end
`else
  assign o_Tx_Ready = !busy_q;
  assign load       = i_Tx_Valid && !busy_q;
  assign load_data  = i_Tx_Data;
`endif

  usrt_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .i_Pclk      (i_Pclk),
    .i_Reset     (i_Reset),
    .i_div       (div_q),
    .i_run       (busy_q),
    .i_clear     (load),
    .o_bit_start (bit_start_unused),
    .o_bit_end   (bit_end),
    .o_Sclk      (o_Sclk)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      div_q     <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      div_q     <= div_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: every state except IDLE advances on bit_end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (load) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (load)         state_d = START;
        else if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output logic: latch config on load, present the next bit on bit_end.
  always_comb begin
    shift_d   = shift_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    div_d     = div_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    if (load) begin
      shift_d   = load_data;
      idx_d     = '0;
      par_en_d  = par_cfg[1];
      par_bit_d = (^load_data) ^ par_cfg[0];
      div_d     = i_Baud_Div;
      serial_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (bit_end) begin
      case (state_q)
        START: begin
          serial_d = shift_q[0];
          shift_d  = shift_q >> 1;
          idx_d    = '0;
        end
        DATA: begin
          if (last_data) begin
            serial_d = par_en_q ? par_bit_q : 1'b1;
          end else begin
            serial_d = shift_q[0];
            shift_d  = shift_q >> 1;
            idx_d    = idx_q + 1'b1;
          end
        end
        PARITY: serial_d = 1'b1;
        STOP: begin
          serial_d = 1'b1;
          busy_d   = 1'b0;
        end
        default: serial_d = 1'b1;
      endcase
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Busy   = busy_q;

endmodule

// File: tb/tb_usrt_tx.sv
// tb_usrt_tx: directed self-checking bench for usrt_tx.
// Define USRT_TX_HOLD_EN for both bench and RTL to exercise the holding register.
module tb_usrt_tx;

  logic       i_Pclk = 1'b0;
  logic       i_Reset;
  logic       i_Tx_Valid;
  logic [7:0] i_Tx_Data;
  logic       o_Tx_Ready;
  logic [7:0] i_Baud_Div;
  logic [1:0] i_Parity;
  logic       o_Tx_Serial;
  logic       o_Sclk;
  logic       o_Tx_Busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic ser_log  [0:2047];
  logic sclk_log [0:2047];
  int   busy_cycles;

`ifdef USRT_TX_HOLD_EN
  localparam int GAP     = 0;
  localparam int DROP_AT = 1;
  localparam logic READY_IN_FRAME = 1'b1;
`else
  localparam int GAP     = 1;
  localparam int DROP_AT = 21;
  localparam logic READY_IN_FRAME = 1'b0;
`endif

  always #5 i_Pclk = ~i_Pclk;

  usrt_tx #(
    .DATA_BITS (8),
    .DIV_WIDTH (8)
  ) dut (
    .i_Pclk      (i_Pclk),
    .i_Reset     (i_Reset),
    .i_Tx_Valid  (i_Tx_Valid),
    .i_Tx_Data   (i_Tx_Data),
    .o_Tx_Ready  (o_Tx_Ready),
    .i_Baud_Div  (i_Baud_Div),
    .i_Parity    (i_Parity),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Sclk      (o_Sclk),
    .o_Tx_Busy   (o_Tx_Busy)
  );

  task automatic tick();
    @(posedge i_Pclk);
    #1;
  endtask

  // Offer one byte for exactly one edge.
  task automatic send(input logic [7:0] d, input logic [7:0] div, input logic [1:0] par);
    i_Tx_Valid = 1'b1;
    i_Tx_Data  = d;
    i_Baud_Div = div;
    i_Parity   = par;
    tick();
    i_Tx_Valid = 1'b0;
    i_Tx_Data  = 8'h00;
  endtask

  // Record serial/sclk each cycle while busy; optionally change config mid-frame.
  task automatic capture(input int chg_at, input logic [7:0] chg_div, input logic [1:0] chg_par);
    busy_cycles = 0;
    while (o_Tx_Busy && busy_cycles < 2000) begin
      ser_log[busy_cycles]  = o_Tx_Serial;
      sclk_log[busy_cycles] = o_Sclk;
      if (busy_cycles == chg_at) begin
        i_Baud_Div = chg_div;
        i_Parity   = chg_par;
      end
      busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    i_Tx_Valid = 1'b0;
    i_Tx_Data = 8'h00;
    i_Baud_Div = 8'd0;
    i_Parity = 2'b00;
    tick();
    tick();
    n_checks++; if (o_Tx_Serial !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b expected 1", o_Tx_Serial); end
    n_checks++; if (o_Sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b expected 1", o_Sclk); end
    n_checks++; if (o_Tx_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_Tx_Busy); end
    n_checks++; if (o_Tx_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_Tx_Ready); end
    i_Reset = 1'b0;
    tick();
    n_checks++; if (o_Sclk !== 1'b1) begin n_fail++; $display("FAIL idle_sclk: got %b expected 1", o_Sclk); end
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp_v;
    exp_v = 16'b0000_0011_0100_1010;  // 0xA5 no parity, bit k = exp_v[k]
    send(8'hA5, 8'd0, 2'b00);
    n_checks++; if (o_Tx_Busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_after_accept: got %b expected 1", o_Tx_Busy); end
    n_checks++; if (o_Tx_Ready !== READY_IN_FRAME) begin n_fail++; $display("FAIL t1_ready_in_frame: got %b expected %b", o_Tx_Ready, READY_IN_FRAME); end
    capture(-1, 8'd0, 2'b00);
    n_checks++; if (busy_cycles !== 20) begin n_fail++; $display("FAIL t1_busy_len: got %0d expected 20", busy_cycles); end
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 2; c++) begin
        n_checks++;
        if (ser_log[k*2+c] !== exp_v[k]) begin n_fail++; $display("FAIL t1_serial bit %0d cyc %0d: got %b expected %b", k, c, ser_log[k*2+c], exp_v[k]); end
        n_checks++;
        if (sclk_log[k*2+c] !== (c == 1)) begin n_fail++; $display("FAIL t1_sclk bit %0d cyc %0d: got %b expected %b", k, c, sclk_log[k*2+c], (c == 1)); end
      end
    end
    n_checks++; if (o_Tx_Serial !== 1'b1 || o_Sclk !== 1'b1 || o_Tx_Ready !== 1'b1) begin
      n_fail++; $display("FAIL t1_idle_after: got ser=%b sclk=%b ready=%b expected 1 1 1", o_Tx_Serial, o_Sclk, o_Tx_Ready);
    end
  endtask

  task automatic test_parity();
    logic [15:0] exp_v;
    logic [1:0]  par;
    int nb;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin par = 2'b01; nb = 11; exp_v = 16'b0000_0101_0100_1010; end
        1: begin par = 2'b10; nb = 11; exp_v = 16'b0000_0111_0100_1010; end
        default: begin par = 2'b11; nb = 10; exp_v = 16'b0000_0011_0100_1010; end
      endcase
      send(8'hA5, 8'd0, par);
      capture(-1, 8'd0, 2'b00);
      n_checks++; if (busy_cycles !== nb*2) begin n_fail++; $display("FAIL t2_busy_len mode %b: got %0d expected %0d", par, busy_cycles, nb*2); end
      for (int k = 0; k < nb; k++) begin
        for (int c = 0; c < 2; c++) begin
          n_checks++;
          if (ser_log[k*2+c] !== exp_v[k]) begin n_fail++; $display("FAIL t2_serial mode %b bit %0d: got %b expected %b", par, k, ser_log[k*2+c], exp_v[k]); end
        end
      end
      tick();
    end
  endtask

  task automatic test_slow_baud();
    logic [15:0] exp_v;
    exp_v = 16'b0000_0010_0000_0010;  // 0x01 no parity
    send(8'h01, 8'd3, 2'b00);
    capture(-1, 8'd0, 2'b00);
    n_checks++; if (busy_cycles !== 80) begin n_fail++; $display("FAIL t3_busy_len: got %0d expected 80", busy_cycles); end
    for (int i = 0; i < 80; i++) begin
      n_checks++;
      if (ser_log[i] !== exp_v[i/8]) begin n_fail++; $display("FAIL t3_serial cyc %0d: got %b expected %b", i, ser_log[i], exp_v[i/8]); end
      n_checks++;
      if (sclk_log[i] !== ((i % 8) >= 4)) begin n_fail++; $display("FAIL t3_sclk cyc %0d: got %b expected %b", i, sclk_log[i], ((i % 8) >= 4)); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1, f2;
    logic e_ser, e_busy, e_sclk;
    int rel;
    f1 = 10'b1000011110;  // 0x0F
    f2 = 10'b1111100000;  // 0xF0
    i_Tx_Valid = 1'b1;
    i_Tx_Data  = 8'h0F;
    i_Baud_Div = 8'd0;
    i_Parity   = 2'b00;
    tick();
    i_Tx_Data = 8'hF0;
    for (int c = 0; c < 43; c++) begin
      if (c < 20) begin
        e_ser = f1[c/2]; e_busy = 1'b1; e_sclk = ((c % 2) == 1);
      end else if (c < 20 + GAP) begin
        e_ser = 1'b1; e_busy = 1'b0; e_sclk = 1'b1;
        n_checks++; if (o_Tx_Ready !== 1'b1) begin n_fail++; $display("FAIL t4_gap_ready cyc %0d: got %b expected 1", c, o_Tx_Ready); end
      end else if (c < 40 + GAP) begin
        rel = c - 20 - GAP;
        e_ser = f2[rel/2]; e_busy = 1'b1; e_sclk = ((rel % 2) == 1);
      end else begin
        e_ser = 1'b1; e_busy = 1'b0; e_sclk = 1'b1;
      end
      n_checks++; if (o_Tx_Serial !== e_ser) begin n_fail++; $display("FAIL t4_serial cyc %0d: got %b expected %b", c, o_Tx_Serial, e_ser); end
      n_checks++; if (o_Tx_Busy !== e_busy) begin n_fail++; $display("FAIL t4_busy cyc %0d: got %b expected %b", c, o_Tx_Busy, e_busy); end
      n_checks++; if (o_Sclk !== e_sclk) begin n_fail++; $display("FAIL t4_sclk cyc %0d: got %b expected %b", c, o_Sclk, e_sclk); end
      if (c == DROP_AT) i_Tx_Valid = 1'b0;
      tick();
    end
    i_Tx_Valid = 1'b0;
  endtask

  task automatic test_config_latch();
    logic [15:0] exp_a, exp_b;
    exp_a = 16'b0000_0010_0111_1000;  // 0x3C no parity
    exp_b = 16'b0000_0100_0111_1000;  // 0x3C even parity (0)
    send(8'h3C, 8'd0, 2'b00);
    capture(3, 8'd5, 2'b01);
    n_checks++; if (busy_cycles !== 20) begin n_fail++; $display("FAIL t5_first_len: got %0d expected 20", busy_cycles); end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (ser_log[i] !== exp_a[i/2]) begin n_fail++; $display("FAIL t5_first_serial cyc %0d: got %b expected %b", i, ser_log[i], exp_a[i/2]); end
    end
    send(8'h3C, 8'd5, 2'b01);
    capture(-1, 8'd5, 2'b01);
    n_checks++; if (busy_cycles !== 132) begin n_fail++; $display("FAIL t5_second_len: got %0d expected 132", busy_cycles); end
    for (int i = 0; i < 132; i++) begin
      n_checks++;
      if (ser_log[i] !== exp_b[i/12]) begin n_fail++; $display("FAIL t5_second_serial cyc %0d: got %b expected %b", i, ser_log[i], exp_b[i/12]); end
      n_checks++;
      if (sclk_log[i] !== ((i % 12) >= 6)) begin n_fail++; $display("FAIL t5_second_sclk cyc %0d: got %b expected %b", i, sclk_log[i], ((i % 12) >= 6)); end
    end
    i_Baud_Div = 8'd0;
    i_Parity   = 2'b00;
    tick();
  endtask

  task automatic test_mid_reset();
    logic [15:0] exp_v;
    exp_v = 16'b0000_0010_0000_0010;  // 0x01 no parity
    send(8'hA5, 8'd0, 2'b00);
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (o_Tx_Busy !== 1'b1 || o_Tx_Serial !== 1'b0 || o_Sclk !== 1'b0) begin
      n_fail++; $display("FAIL t6_pre_reset: got busy=%b ser=%b sclk=%b expected 1 0 0", o_Tx_Busy, o_Tx_Serial, o_Sclk);
    end
    i_Reset = 1'b1;
    tick();
    n_checks++; if (o_Tx_Serial !== 1'b1) begin n_fail++; $display("FAIL t6_serial: got %b expected 1", o_Tx_Serial); end
    n_checks++; if (o_Sclk !== 1'b1) begin n_fail++; $display("FAIL t6_sclk: got %b expected 1", o_Sclk); end
    n_checks++; if (o_Tx_Busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy: got %b expected 0", o_Tx_Busy); end
    n_checks++; if (o_Tx_Ready !== 1'b1) begin n_fail++; $display("FAIL t6_ready: got %b expected 1", o_Tx_Ready); end
    i_Reset = 1'b0;
    send(8'h01, 8'd0, 2'b00);
    capture(-1, 8'd0, 2'b00);
    n_checks++; if (busy_cycles !== 20) begin n_fail++; $display("FAIL t6_after_len: got %0d expected 20", busy_cycles); end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (ser_log[i] !== exp_v[i/2]) begin n_fail++; $display("FAIL t6_after_serial cyc %0d: got %b expected %b", i, ser_log[i], exp_v[i/2]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_slow_baud();
    test_back_to_back();
    test_config_latch();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
